// File: rtl/exe_redirect_ctrl_pkg.sv
// Shared constants for the execute-stage redirect controller: FSM state encodings,
// event-kind codes, field widths and the SWI vector-target helper.
package exe_redirect_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 6;
  localparam int SWI_W  = 11;
  localparam int WDT_W  = 8;

  // Final unacknowledged REQ cycle index; the 255th such cycle expires the request.
  localparam logic [WDT_W-1:0] WDT_LAST = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_IDTS_WAIT = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_REQ       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_JUMP = 2'd0,
    KIND_SWI  = 2'd1,
    KIND_INTR = 2'd2,
    KIND_IDTS = 2'd3
  } kind_e;

  // Vector entries are word sized; the sum wraps at 32 bits.
  function automatic logic [ADDR_W-1:0] swi_target(input logic [ADDR_W-1:0] base,
                                                   input logic [SWI_W-1:0]  number);
    return base + {{(ADDR_W-SWI_W-2){1'b0}}, number, 2'b00};
  endfunction

endpackage

// File: rtl/exe_redirect_ctrl_wdt.sv
// Redirect watchdog: counts unacknowledged REQ cycles and expires the request on the
// 255th one. Only instantiated when EXE_REDIRECT_TIMEOUT_EN is defined.
module exe_redirect_wdt
  import exe_redirect_ctrl_pkg::*;
(
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iREQ_ACTIVE,
  input  logic iACK,
  output logic oEXPIRE,
  output logic oTIMEOUT
);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign oEXPIRE = iREQ_ACTIVE && !iACK && (cnt_q == WDT_LAST);

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = oEXPIRE;
    if (!iREQ_ACTIVE || iACK || oEXPIRE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign oTIMEOUT = timeout_q;

endmodule

// File: rtl/exe_redirect_ctrl.sv
// Execute-stage redirect controller: arbitrates JUMP/SWI/INTR/IDTS events, flushes the
// pipeline and hands the target to fetch. Optional watchdog: EXE_REDIRECT_TIMEOUT_EN.
module exe_redirect_ctrl
  import exe_redirect_ctrl_pkg::*;
(
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iJUMP_ACTIVE,
  input  logic [ADDR_W-1:0] iJUMP_ADDR,
  input  logic              iSWI_ACTIVE,
  input  logic [SWI_W-1:0]  iSWI_NUMBER,
  input  logic              iINTR_ACTIVE,
  input  logic [ADDR_W-1:0] iINTR_ADDR,
  input  logic              iIDTS_ACTIVE,
  input  logic [ADDR_W-1:0] iIDTS_R_ADDR,
  input  logic [TAG_W-1:0]  iIDTS_COMMIT_TAG,
  input  logic [ADDR_W-1:0] iSWI_VECTOR_BASE,
  input  logic              iCOMMIT_VALID,
  input  logic [TAG_W-1:0]  iCOMMIT_TAG,
  input  logic              iFETCH_REDIRECT_ACK,
  output logic              oFREE_RESTART,
  output logic              oFETCH_REDIRECT_REQ,
  output logic [ADDR_W-1:0] oFETCH_REDIRECT_ADDR,
  output logic              oIDT_SAVE_VALID,
  output logic [ADDR_W-1:0] oIDT_SAVE_ADDR,
  output logic              oBUSY,
  output logic [1:0]        oEVENT_KIND,
  output logic              oEVENT_DROP,
  output logic              oREDIRECT_TIMEOUT
);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] save_addr_q, save_addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              drop_q, drop_d;
  logic              any_event;
  logic              commit_hit;
  logic              wdt_expire;

  assign any_event  = iJUMP_ACTIVE | iSWI_ACTIVE | iINTR_ACTIVE | iIDTS_ACTIVE;
  // The save pulse must coincide with the retiring commit, so it is decoded, not registered.
  assign commit_hit = (state_q == ST_IDTS_WAIT) && iCOMMIT_VALID && (iCOMMIT_TAG == tag_q);

`ifdef EXE_REDIRECT_TIMEOUT_EN
  exe_redirect_wdt u_wdt (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iREQ_ACTIVE (state_q == ST_REQ),
    .iACK        (iFETCH_REDIRECT_ACK),
    .oEXPIRE     (wdt_expire),
    .oTIMEOUT    (oREDIRECT_TIMEOUT)
  );
`else
  assign wdt_expire        = 1'b0;
  assign oREDIRECT_TIMEOUT = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    kind_d      = kind_q;
    target_d    = target_q;
    save_addr_d = save_addr_q;
    tag_d       = tag_q;
    drop_d      = any_event && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (iINTR_ACTIVE) begin
          kind_d   = KIND_INTR;
          target_d = iINTR_ADDR;
          state_d  = ST_FLUSH;
        end else if (iSWI_ACTIVE) begin
          kind_d   = KIND_SWI;
          target_d = swi_target(iSWI_VECTOR_BASE, iSWI_NUMBER);
          state_d  = ST_FLUSH;
        end else if (iIDTS_ACTIVE) begin
          kind_d      = KIND_IDTS;
          target_d    = iIDTS_R_ADDR;
          save_addr_d = iIDTS_R_ADDR;
          tag_d       = iIDTS_COMMIT_TAG;
          state_d     = ST_IDTS_WAIT;
        end else if (iJUMP_ACTIVE) begin
          kind_d   = KIND_JUMP;
          target_d = iJUMP_ADDR;
          state_d  = ST_FLUSH;
        end
      end
      ST_IDTS_WAIT: if (commit_hit) state_d = ST_FLUSH;
      ST_FLUSH:     state_d = ST_REQ;
      ST_REQ: begin
        if (iFETCH_REDIRECT_ACK || wdt_expire) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_JUMP;
      target_q    <= '0;
      save_addr_q <= '0;
      tag_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      state_q     <= state_d;
      kind_q      <= kind_d;
      target_q    <= target_d;
      save_addr_q <= save_addr_d;
      tag_q       <= tag_d;
      drop_q      <= drop_d;
    end
  end

  assign oBUSY                = (state_q != ST_IDLE);
  assign oFREE_RESTART        = (state_q == ST_FLUSH);
  assign oFETCH_REDIRECT_REQ  = (state_q == ST_REQ);
  assign oFETCH_REDIRECT_ADDR = (state_q == ST_REQ) ? target_q : '0;
  assign oIDT_SAVE_VALID      = commit_hit;
  assign oIDT_SAVE_ADDR       = commit_hit ? save_addr_q : '0;
  assign oEVENT_KIND          = kind_q;
  assign oEVENT_DROP          = drop_q;

endmodule

// File: tb/tb_exe_redirect_ctrl.sv
// Self-checking bench for exe_redirect_ctrl: expected redirects and IDT saves are queued
// at stimulus time and popped by a monitor when the DUT hands them over.
module tb_exe_redirect_ctrl;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iJUMP_ACTIVE = 1'b0, iSWI_ACTIVE = 1'b0, iINTR_ACTIVE = 1'b0, iIDTS_ACTIVE = 1'b0;
  logic [31:0] iJUMP_ADDR = '0, iINTR_ADDR = '0, iIDTS_R_ADDR = '0, iSWI_VECTOR_BASE = '0;
  logic [10:0] iSWI_NUMBER = '0;
  logic [5:0]  iIDTS_COMMIT_TAG = '0, iCOMMIT_TAG = '0;
  logic        iCOMMIT_VALID = 1'b0, iFETCH_REDIRECT_ACK = 1'b0;
  logic        oFREE_RESTART, oFETCH_REDIRECT_REQ, oIDT_SAVE_VALID, oBUSY, oEVENT_DROP;
  logic        oREDIRECT_TIMEOUT;
  logic [31:0] oFETCH_REDIRECT_ADDR, oIDT_SAVE_ADDR;
  logic [1:0]  oEVENT_KIND;

  exe_redirect_ctrl dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iJUMP_ACTIVE(iJUMP_ACTIVE), .iJUMP_ADDR(iJUMP_ADDR),
    .iSWI_ACTIVE(iSWI_ACTIVE), .iSWI_NUMBER(iSWI_NUMBER),
    .iINTR_ACTIVE(iINTR_ACTIVE), .iINTR_ADDR(iINTR_ADDR),
    .iIDTS_ACTIVE(iIDTS_ACTIVE), .iIDTS_R_ADDR(iIDTS_R_ADDR),
    .iIDTS_COMMIT_TAG(iIDTS_COMMIT_TAG), .iSWI_VECTOR_BASE(iSWI_VECTOR_BASE),
    .iCOMMIT_VALID(iCOMMIT_VALID), .iCOMMIT_TAG(iCOMMIT_TAG),
    .iFETCH_REDIRECT_ACK(iFETCH_REDIRECT_ACK),
    .oFREE_RESTART(oFREE_RESTART), .oFETCH_REDIRECT_REQ(oFETCH_REDIRECT_REQ),
    .oFETCH_REDIRECT_ADDR(oFETCH_REDIRECT_ADDR), .oIDT_SAVE_VALID(oIDT_SAVE_VALID),
    .oIDT_SAVE_ADDR(oIDT_SAVE_ADDR), .oBUSY(oBUSY), .oEVENT_KIND(oEVENT_KIND),
    .oEVENT_DROP(oEVENT_DROP), .oREDIRECT_TIMEOUT(oREDIRECT_TIMEOUT)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  kind;
  } rdr_t;

  rdr_t        rdr_q[$];
  logic [31:0] save_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic clear_events();
    iJUMP_ACTIVE = 1'b0; iSWI_ACTIVE = 1'b0; iINTR_ACTIVE = 1'b0; iIDTS_ACTIVE = 1'b0;
  endtask

  // Called one cycle after the event was sampled: expects FLUSH, then REQ held for
  // ack_delay extra cycles before the ack cycle, then IDLE.
  task automatic finish_redirect(input logic [31:0] exp_addr, input int ack_delay);
    check("flush_restart", oFREE_RESTART, 1'b1);
    check("flush_no_req", oFETCH_REDIRECT_REQ, 1'b0);
    check("flush_addr_zero", oFETCH_REDIRECT_ADDR, 32'h0);
    tick();
    check("req_start", oFETCH_REDIRECT_REQ, 1'b1);
    check("req_addr", oFETCH_REDIRECT_ADDR, exp_addr);
    check("req_restart_off", oFREE_RESTART, 1'b0);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check("req_held", oFETCH_REDIRECT_REQ, 1'b1);
      check("req_addr_stable", oFETCH_REDIRECT_ADDR, exp_addr);
    end
    iFETCH_REDIRECT_ACK = 1'b1;
    tick();
    iFETCH_REDIRECT_ACK = 1'b0;
    check("idle_after_ack", oBUSY, 1'b0);
    check("idle_req_off", oFETCH_REDIRECT_REQ, 1'b0);
  endtask

  task automatic issue_jump(input logic [31:0] addr);
    iJUMP_ACTIVE = 1'b1; iJUMP_ADDR = addr;
    rdr_q.push_back('{addr: addr, kind: 2'd0});
    tick();
    clear_events();
  endtask

  // Monitor: accepted redirects and IDT saves are popped against the scoreboard.
  always @(negedge iCLOCK) begin : monitor
    rdr_t        e;
    logic [31:0] s;
    if (inRESET) begin
      if (oFETCH_REDIRECT_REQ && iFETCH_REDIRECT_ACK) begin
        check("rdr_expected", rdr_q.size() != 0, 1'b1);
        if (rdr_q.size() != 0) begin
          e = rdr_q.pop_front();
          check("rdr_addr", oFETCH_REDIRECT_ADDR, e.addr);
          check("rdr_kind", oEVENT_KIND, e.kind);
        end
      end
      if (oIDT_SAVE_VALID) begin
        check("save_expected", save_q.size() != 0, 1'b1);
        if (save_q.size() != 0) begin
          s = save_q.pop_front();
          check("save_addr", oIDT_SAVE_ADDR, s);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin : stim
    int   to_seen;
    int   req_cycles;
    // Reset state, before any clock edge
    #2;
    check("rst_busy", oBUSY, 1'b0);
    check("rst_restart", oFREE_RESTART, 1'b0);
    check("rst_req", oFETCH_REDIRECT_REQ, 1'b0);
    check("rst_addr", oFETCH_REDIRECT_ADDR, 32'h0);
    check("rst_save", oIDT_SAVE_VALID, 1'b0);
    check("rst_kind", oEVENT_KIND, 2'd0);
    check("rst_drop", oEVENT_DROP, 1'b0);
    check("rst_timeout", oREDIRECT_TIMEOUT, 1'b0);
    tick();
    inRESET = 1'b1;
    tick();

    // Ack while IDLE is ignored
    iFETCH_REDIRECT_ACK = 1'b1;
    tick();
    iFETCH_REDIRECT_ACK = 1'b0;
    check("idle_ack_ignored", oBUSY, 1'b0);

    // JUMP 0x1000, ack on second REQ cycle
    issue_jump(32'h0000_1000);
    check("jump_kind", oEVENT_KIND, 2'd0);
    finish_redirect(32'h0000_1000, 1);

    // SWI wrap-around; ack held high through FLUSH must not shorten the sequence
    iSWI_ACTIVE = 1'b1; iSWI_NUMBER = 11'h7FF; iSWI_VECTOR_BASE = 32'hFFFF_F000;
    rdr_q.push_back('{addr: 32'h0000_0FFC, kind: 2'd1});
    tick();
    clear_events();
    iFETCH_REDIRECT_ACK = 1'b1;
    check("swi_restart", oFREE_RESTART, 1'b1);
    tick();
    check("swi_req_after_flush", oFETCH_REDIRECT_REQ, 1'b1);
    check("swi_addr_wrap", oFETCH_REDIRECT_ADDR, 32'h0000_0FFC);
    tick();
    iFETCH_REDIRECT_ACK = 1'b0;
    check("swi_idle", oBUSY, 1'b0);

    // INTR and JUMP together: INTR wins, no drop
    iINTR_ACTIVE = 1'b1; iINTR_ADDR = 32'h0000_0200;
    iJUMP_ACTIVE = 1'b1; iJUMP_ADDR = 32'h0000_0300;
    rdr_q.push_back('{addr: 32'h0000_0200, kind: 2'd2});
    tick();
    clear_events();
    check("prio_no_drop", oEVENT_DROP, 1'b0);
    check("prio_kind", oEVENT_KIND, 2'd2);
    finish_redirect(32'h0000_0200, 0);

    // IDTS tag 5 waits for its commit, saves, flushes, redirects
    iIDTS_ACTIVE = 1'b1; iIDTS_R_ADDR = 32'h0000_0104; iIDTS_COMMIT_TAG = 6'd5;
    save_q.push_back(32'h0000_0104);
    rdr_q.push_back('{addr: 32'h0000_0104, kind: 2'd3});
    tick();
    clear_events();
    check("idts_busy", oBUSY, 1'b1);
    check("idts_no_restart", oFREE_RESTART, 1'b0);
    check("idts_kind", oEVENT_KIND, 2'd3);
    for (int t = 3; t <= 4; t++) begin
      iCOMMIT_VALID = 1'b1; iCOMMIT_TAG = 6'(t);
      #1;
      check("idts_other_tag_nosave", oIDT_SAVE_VALID, 1'b0);
      check("idts_other_tag_addr0", oIDT_SAVE_ADDR, 32'h0);
      tick();
      check("idts_still_waiting", oFREE_RESTART, 1'b0);
    end
    iCOMMIT_TAG = 6'd5;
    #1;
    check("idts_save_pulse", oIDT_SAVE_VALID, 1'b1);
    check("idts_save_addr", oIDT_SAVE_ADDR, 32'h0000_0104);
    tick();
    iCOMMIT_VALID = 1'b0;
    check("idts_save_done", oIDT_SAVE_VALID, 1'b0);
    finish_redirect(32'h0000_0104, 2);

    // JUMP arriving during REQ is dropped, original redirect survives
    issue_jump(32'h0000_0400);
    tick();
    check("drop_in_req", oFETCH_REDIRECT_REQ, 1'b1);
    iJUMP_ACTIVE = 1'b1; iJUMP_ADDR = 32'h0000_0500;
    tick();
    clear_events();
    check("drop_pulse", oEVENT_DROP, 1'b1);
    check("drop_req_kept", oFETCH_REDIRECT_REQ, 1'b1);
    check("drop_addr_kept", oFETCH_REDIRECT_ADDR, 32'h0000_0400);
    iFETCH_REDIRECT_ACK = 1'b1;
    tick();
    iFETCH_REDIRECT_ACK = 1'b0;
    check("drop_one_cycle", oEVENT_DROP, 1'b0);
    check("drop_idle", oBUSY, 1'b0);

    // Reset while in IDTS_WAIT abandons the event silently
    iIDTS_ACTIVE = 1'b1; iIDTS_R_ADDR = 32'h0000_0800; iIDTS_COMMIT_TAG = 6'd9;
    tick();
    clear_events();
    check("rst_mid_busy_before", oBUSY, 1'b1);
    #2;
    inRESET = 1'b0;
    iCOMMIT_VALID = 1'b1; iCOMMIT_TAG = 6'd9;
    #1;
    check("rst_mid_busy", oBUSY, 1'b0);
    check("rst_mid_save", oIDT_SAVE_VALID, 1'b0);
    check("rst_mid_save_addr", oIDT_SAVE_ADDR, 32'h0);
    check("rst_mid_kind", oEVENT_KIND, 2'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_hold_restart", oFREE_RESTART, 1'b0);
      check("rst_hold_req", oFETCH_REDIRECT_REQ, 1'b0);
    end
    iCOMMIT_VALID = 1'b0;
    inRESET = 1'b1;
    tick();
    check("rst_release_idle", oBUSY, 1'b0);
    check("rst_release_restart", oFREE_RESTART, 1'b0);

    // Random JUMP/INTR redirects with random ack delays
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      int          d;
      a = $urandom() & 32'hFFFF_FFFC;
      d = $urandom_range(0, 3);
      if (i % 2 == 0) begin
        iJUMP_ACTIVE = 1'b1; iJUMP_ADDR = a;
        rdr_q.push_back('{addr: a, kind: 2'd0});
      end else begin
        iINTR_ACTIVE = 1'b1; iINTR_ADDR = a;
        rdr_q.push_back('{addr: a, kind: 2'd2});
      end
      tick();
      clear_events();
      finish_redirect(a, d);
    end

`ifdef EXE_REDIRECT_TIMEOUT_EN
    // Ack withheld: watchdog fires after 255 REQ cycles and returns to IDLE
    iJUMP_ACTIVE = 1'b1; iJUMP_ADDR = 32'h0000_0900;
    tick();
    clear_events();
    tick();
    req_cycles = 0;
    to_seen = 0;
    for (int i = 0; i < 400 && to_seen == 0; i++) begin
      if (oFETCH_REDIRECT_REQ) req_cycles++;
      tick();
      if (oREDIRECT_TIMEOUT) to_seen = 1;
    end
    check("wdt_fired", to_seen, 1);
    check("wdt_req_cycles", req_cycles, 255);
    check("wdt_idle", oBUSY, 1'b0);
    tick();
    check("wdt_pulse_one_cycle", oREDIRECT_TIMEOUT, 1'b0);
`else
    // Without the watchdog REQ waits indefinitely
    issue_jump(32'h0000_0A00);
    tick();
    to_seen = 0;
    req_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (oREDIRECT_TIMEOUT) to_seen = 1;
      if (oFETCH_REDIRECT_REQ) req_cycles++;
      tick();
    end
    check("nowdt_no_timeout", to_seen, 0);
    check("nowdt_req_held", req_cycles, 300);
    check("nowdt_addr", oFETCH_REDIRECT_ADDR, 32'h0000_0A00);
    iFETCH_REDIRECT_ACK = 1'b1;
    tick();
    iFETCH_REDIRECT_ACK = 1'b0;
    check("nowdt_idle", oBUSY, 1'b0);
`endif

    tick();
    check("rdr_queue_drained", rdr_q.size(), 0);
    check("save_queue_drained", save_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_redirect_ctrl.md
EXE_REDIRECT_CTRL -- requirements
Module: exe_redirect_ctrl

Interface
REQ-001 SHALL have: iCLOCK  in  1  clock, rising edge.
REQ-002 SHALL have: inRESET  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: iJUMP_ACTIVE in 1, iJUMP_ADDR in 32  taken-branch event and target.
REQ-004 SHALL have: iSWI_ACTIVE in 1, iSWI_NUMBER in 11  software-interrupt event and number.
REQ-005 SHALL have: iINTR_ACTIVE in 1, iINTR_ADDR in 32  interrupt-return event and target.
REQ-006 SHALL have: iIDTS_ACTIVE in 1, iIDTS_R_ADDR in 32, iIDTS_COMMIT_TAG in 6  IDT-set event, return address, commit tag.
REQ-007 SHALL have: iSWI_VECTOR_BASE  in  32  SWI vector table base.
REQ-008 SHALL have: iCOMMIT_VALID in 1, iCOMMIT_TAG in 6  retirement report.
REQ-009 SHALL have: iFETCH_REDIRECT_ACK  in  1  fetch accepted redirect.
REQ-010 SHALL have: oFREE_RESTART  out  1  one-cycle pipeline flush.
REQ-011 SHALL have: oFETCH_REDIRECT_REQ out 1, oFETCH_REDIRECT_ADDR out 32  redirect request and target.
REQ-012 SHALL have: oIDT_SAVE_VALID out 1, oIDT_SAVE_ADDR out 32  one-cycle IDT return-address save.
REQ-013 SHALL have: oBUSY out 1, oEVENT_KIND out 2  not-IDLE flag; latched kind (0 JUMP, 1 SWI, 2 INTR, 3 IDTS).
REQ-014 SHALL have: oEVENT_DROP  out  1  one-cycle pulse, event arrived while busy.
REQ-015 SHALL have: oREDIRECT_TIMEOUT  out  1  one-cycle watchdog pulse (see Configuration).

Function
REQ-016 States SHALL be IDLE, IDTS_WAIT, FLUSH, REQ.
REQ-017 In IDLE, simultaneous events SHALL be resolved by priority INTR > SWI > IDTS > JUMP; lower-priority ones discarded without oEVENT_DROP.
REQ-018 Winning event in IDLE SHALL latch kind and target; JUMP/INTR target = input address; SWI target = iSWI_VECTOR_BASE + {iSWI_NUMBER, 2'b00}, 32-bit wrap-around.
REQ-019 IDLE -> FLUSH on JUMP/SWI/INTR; IDLE -> IDTS_WAIT on IDTS, latching iIDTS_R_ADDR as both save address and redirect target, plus tag.
REQ-020 IDTS_WAIT SHALL hold until iCOMMIT_VALID && iCOMMIT_TAG == latched tag; same cycle pulse oIDT_SAVE_VALID with oIDT_SAVE_ADDR valid; next state FLUSH.
REQ-021 FLUSH SHALL last exactly one cycle with oFREE_RESTART=1, then REQ.
REQ-022 REQ SHALL hold oFETCH_REDIRECT_REQ=1 and oFETCH_REDIRECT_ADDR stable until iFETCH_REDIRECT_ACK=1; ack cycle is last REQ cycle; next state IDLE.
REQ-023 Latency JUMP: event sampled edge N -> oFREE_RESTART during cycle N+1 -> oFETCH_REDIRECT_REQ from cycle N+2.
REQ-024 iFETCH_REDIRECT_ACK outside REQ SHALL be ignored.
REQ-025 Any *_ACTIVE input while not IDLE SHALL pulse oEVENT_DROP next cycle and leave state unchanged.
REQ-026 oFETCH_REDIRECT_ADDR SHALL read 0 outside REQ; oIDT_SAVE_ADDR SHALL read 0 when oIDT_SAVE_VALID=0.
REQ-027 oBUSY SHALL equal (state != IDLE).

Reset
REQ-028 On inRESET low, state SHALL be IDLE and all outputs, latched addresses, tag, kind and watchdog SHALL be 0, immediately and independent of clock.
REQ-029 Reset mid-operation SHALL abandon the event without emitting any flush, save or request pulse.

Configuration
REQ-030 With EXE_REDIRECT_TIMEOUT_EN defined, an 8-bit watchdog SHALL count REQ cycles without ack; when it reaches 255 the block SHALL pulse oREDIRECT_TIMEOUT, drop the request and return to IDLE.
REQ-031 Without EXE_REDIRECT_TIMEOUT_EN, REQ SHALL wait indefinitely and oREDIRECT_TIMEOUT SHALL be tied 0.

Structure
REQ-032 State encodings and oEVENT_KIND codes SHALL be shared constants in core.h.
REQ-033 Watchdog SHALL be a sub-module exe_redirect_wdt, instantiated only under EXE_REDIRECT_TIMEOUT_EN.

Verification
REQ-034 JUMP 0x0000_1000 at edge N, ack at N+3 -> restart pulse cycle N+1, REQ with addr 0x0000_1000 cycles N+2..N+3, IDLE at N+4.
REQ-035 SWI number 0x7FF, base 0xFFFF_F000 -> redirect addr 0x0000_0FFC (wrap).
REQ-036 INTR 0x200 and JUMP 0x300 same cycle -> single redirect to 0x200, no oEVENT_DROP.
REQ-037 IDTS tag 5, addr 0x104; commits tags 3,4,5 -> oIDT_SAVE_VALID with 0x104 on tag-5 cycle, then flush, then redirect to 0x104.
REQ-038 JUMP arriving while in REQ -> oEVENT_DROP one cycle, original redirect unaffected; reset asserted in IDTS_WAIT -> all outputs 0, no pulses.
REQ-039 With EXE_REDIRECT_TIMEOUT_EN, ack never given -> oREDIRECT_TIMEOUT after 255 REQ cycles, then IDLE.
